// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_stage_pkg;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        epoch;
  } fetch_tag_t;

  // Bit 0 is always cleared; bit 1 survives so the caller can flag misalignment.
  function automatic logic [31:0] redirect_target(input logic [31:0] base,
                                                  input logic [31:0] offset);
    return (base + offset) & 32'hFFFF_FFFE;
  endfunction

endpackage

// File: rtl/fetch_stage_sync_fifo.sv
// Synchronous FIFO with push/pop/clear; a push onto a full FIFO lands only when a pop frees a slot.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  always_comb begin
    empty_o = (count_q == '0);
    full_o  = (count_q == CW'(DEPTH));
    do_pop  = pop_i && !empty_o;
    do_push = push_i && (!full_o || do_pop);
    data_o  = mem_q[rd_ptr_q];
    count_o = count_q;
  end

  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_q <= count_q + CW'(1);
      else if (do_pop && !do_push) count_q <= count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear_i && !reset) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, credit-limited in-order memory requests, wrong-path squashing,
// and a small instruction FIFO feeding decode.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = fetch_stage_pkg::RESET_PC,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR  = fetch_stage_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_base,
  input  logic [31:0] redirect_offset,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instruction,
  output logic [31:0] if_pc,
  output logic        fetch_misaligned
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   pc_q, pc_d;
  logic          epoch_q, epoch_d;
  logic [CW-1:0] drop_q, drop_d;

  fetch_tag_t    tag_in, tag_head;
  logic          tag_push, tag_pop, tag_empty, tag_full;
  logic [CW-1:0] tag_count;

  fetch_entry_t  out_in, out_head;
  logic          out_push, out_pop, out_clear, out_empty, out_full;
  logic [CW-1:0] out_count;

  logic [31:0]   target;

  sync_fifo #(.WIDTH($bits(fetch_tag_t)), .DEPTH(FIFO_DEPTH)) u_tag_q (
    .clk(clk), .reset(reset), .clear_i(1'b0),
    .push_i(tag_push), .data_i(tag_in), .pop_i(tag_pop), .data_o(tag_head),
    .empty_o(tag_empty), .full_o(tag_full), .count_o(tag_count)
  );

  sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(FIFO_DEPTH)) u_out_q (
    .clk(clk), .reset(reset), .clear_i(out_clear),
    .push_i(out_push), .data_i(out_in), .pop_i(out_pop), .data_o(out_head),
    .empty_o(out_empty), .full_o(out_full), .count_o(out_count)
  );

  // drop_q counts tags issued before the latest redirect; with a 1-bit epoch two
  // redirects in a row would otherwise let old-path words alias as current ones.
  always_comb begin
    target           = redirect_target(redirect_base, redirect_offset);
    fetch_misaligned = !reset && redirect_valid && target[1];

    if_valid       = !reset && !out_empty;
    if_instruction = if_valid ? out_head.instr : NOP_INSTR;
    if_pc          = if_valid ? out_head.pc : 32'h0;
    out_pop        = if_valid && if_ready;
    out_clear      = redirect_valid;

    imem_req_addr  = reset ? RESET_PC : pc_q;
    imem_req_valid = !reset && !redirect_valid &&
                     ((int'(tag_count) + int'(out_count) - int'(out_pop)) < FIFO_DEPTH);
    tag_push       = imem_req_valid && imem_req_ready;
    tag_in         = '{pc: pc_q, epoch: epoch_q};

    tag_pop  = !reset && imem_rsp_valid && !tag_empty;
    out_push = tag_pop && !redirect_valid && (drop_q == '0) && (tag_head.epoch == epoch_q);
    out_in   = '{pc: tag_head.pc, instr: imem_rsp_data};

    pc_d    = pc_q;
    epoch_d = epoch_q;
    drop_d  = drop_q;
    if (redirect_valid) begin
      pc_d    = {target[31:2], 2'b00};
      epoch_d = !epoch_q;
      drop_d  = tag_count - CW'(tag_pop);
    end else begin
      if (tag_push) pc_d = pc_q + 32'd4;
      if (tag_pop && (drop_q != '0)) drop_d = drop_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      epoch_q <= 1'b0;
      drop_q  <= '0;
    end else begin
      pc_q    <= pc_d;
      epoch_q <= epoch_d;
      drop_q  <= drop_d;
    end
  end

  a_no_out_overflow: assert property (@(posedge clk) disable iff (reset)
    !(out_push && out_full && !out_pop));
  a_no_tag_overflow: assert property (@(posedge clk) disable iff (reset)
    !(tag_push && tag_full && !tag_pop));

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by a randomized run,
// compared every cycle against a queue-based model of the fetch pipeline.
module tb_fetch_stage;

  localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TB_NOP      = 32'h0000_0013;
  localparam int          DEPTH       = 2;

  logic        clk = 1'b0;
  logic        reset, imemReqValid, imemReqReady, imemRspValid;
  logic        redirectValid, ifValid, ifReady, fetchMisaligned;
  logic [31:0] imemReqAddr, imemRspData, redirectBase, redirectOffset, ifInstruction, ifPc;

  typedef struct { logic [31:0] pc; logic live; } flight_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } outEntry_t;
  typedef struct { logic [31:0] addr; int due; } memReq_t;

  flight_t     inflight[$];
  outEntry_t   outQ[$];
  memReq_t     memQ[$];
  logic [31:0] modelPc;
  int          cyc, lat, lastDue, vectors, miscompares, validCount;

  fetch_stage #(.RESET_PC(TB_RESET_PC), .FIFO_DEPTH(DEPTH), .NOP_INSTR(TB_NOP)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imemReqValid), .imem_req_ready(imemReqReady), .imem_req_addr(imemReqAddr),
    .imem_rsp_valid(imemRspValid), .imem_rsp_data(imemRspData),
    .redirect_valid(redirectValid), .redirect_base(redirectBase), .redirect_offset(redirectOffset),
    .if_valid(ifValid), .if_ready(ifReady), .if_instruction(ifInstruction), .if_pc(ifPc),
    .fetch_misaligned(fetchMisaligned)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    return (addr * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  task automatic compare(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  // Sampled mid-cycle: predict outputs from the model, compare, then advance the model
  // by the events that take effect on the coming rising edge.
  task automatic checkOutput();
    logic        expValid, expPop, expReq, expMis;
    logic [31:0] expPc, expInstr, expAddr, tgt;
    flight_t     f;
    int          due;
    tgt      = (redirectBase + redirectOffset) & 32'hFFFF_FFFE;
    expValid = !reset && (outQ.size() > 0);
    expPop   = expValid && ifReady;
    expPc    = 32'h0;
    expInstr = TB_NOP;
    if (expValid) begin
      expPc    = outQ[0].pc;
      expInstr = outQ[0].instr;
    end
    expReq  = !reset && !redirectValid && ((inflight.size() + outQ.size() - int'(expPop)) < DEPTH);
    expAddr = reset ? TB_RESET_PC : modelPc;
    expMis  = !reset && redirectValid && tgt[1];

    compare("if_valid", 32'(ifValid), 32'(expValid));
    compare("if_pc", ifPc, expPc);
    compare("if_instruction", ifInstruction, expInstr);
    compare("imem_req_valid", 32'(imemReqValid), 32'(expReq));
    compare("imem_req_addr", imemReqAddr, expAddr);
    compare("fetch_misaligned", 32'(fetchMisaligned), 32'(expMis));
    if (ifValid) validCount++;

    if (imemReqValid && imemReqReady) begin
      due = (cyc + lat > lastDue + 1) ? cyc + lat : lastDue + 1;
      memQ.push_back('{addr: imemReqAddr, due: due});
      lastDue = due;
    end

    if (reset) begin
      modelPc = TB_RESET_PC;
      inflight.delete();
      outQ.delete();
    end else begin
      if (expPop) outQ.delete(0);
      if (imemRspValid && inflight.size() > 0) begin
        f = inflight[0];
        inflight.delete(0);
        if (!redirectValid && f.live) outQ.push_back('{pc: f.pc, instr: memWord(f.pc)});
      end
      if (redirectValid) begin
        foreach (inflight[i]) inflight[i].live = 1'b0;
        outQ.delete();
        modelPc = tgt & 32'hFFFF_FFFC;
      end else if (expReq && imemReqReady) begin
        inflight.push_back('{pc: modelPc, live: 1'b1});
        modelPc = modelPc + 32'd4;
      end
    end
    cyc++;
  endtask

  task automatic applyStimulus(input logic rst, input logic reqReady, input logic decReady,
                               input logic redir, input logic [31:0] base, input logic [31:0] offset);
    reset          = rst;
    imemReqReady   = reqReady;
    ifReady        = decReady;
    redirectValid  = redir;
    redirectBase   = base;
    redirectOffset = offset;
    if (memQ.size() > 0 && memQ[0].due <= cyc) begin
      imemRspValid = 1'b1;
      imemRspData  = memWord(memQ[0].addr);
      memQ.delete(0);
    end else begin
      imemRspValid = 1'b0;
      imemRspData  = $urandom;
    end
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
  endtask

  task automatic runCycles(input int n, input logic reqReady, input logic decReady);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, reqReady, decReady, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic redirect(input logic [31:0] base, input logic [31:0] offset);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, base, offset);
  endtask

  initial begin
    reset = 1'b1; imemReqReady = 1'b0; ifReady = 1'b0; redirectValid = 1'b0;
    redirectBase = '0; redirectOffset = '0; imemRspValid = 1'b0; imemRspData = '0;
    modelPc = TB_RESET_PC; cyc = 0; lat = 1; lastDue = -1;
    vectors = 0; miscompares = 0; validCount = 0;
    @(posedge clk);
    #1;

    $display("[TB] reset and free-run at latency 1");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
    runCycles(4, 1'b1, 1'b1);
    validCount = 0;
    runCycles(8, 1'b1, 1'b1);
    compare("throughput", 32'(validCount), 32'd8);

    $display("[TB] decode stall");
    runCycles(5, 1'b1, 1'b0);
    runCycles(6, 1'b1, 1'b1);

    $display("[TB] redirect with fetches in flight");
    lat = 3;
    runCycles(4, 1'b1, 1'b1);
    redirect(32'h0000_0010, 32'h0000_0020);
    runCycles(10, 1'b1, 1'b1);

    $display("[TB] misaligned redirect");
    lat = 1;
    redirect(32'h0000_0100, 32'hFFFF_FFF6);
    runCycles(6, 1'b1, 1'b1);

    $display("[TB] toggling request ready, latency 3");
    lat = 3;
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, (i % 2) == 0, 1'b1, 1'b0, 32'h0, 32'h0);

    $display("[TB] back-to-back redirects");
    runCycles(3, 1'b1, 1'b1);
    redirect(32'h0000_0200, 32'h0);
    redirect(32'h0000_0400, 32'h0);
    runCycles(10, 1'b1, 1'b1);
    runCycles(2, 1'b1, 1'b1);
    redirect(32'h0000_0500, 32'h0);
    runCycles(1, 1'b1, 1'b1);
    redirect(32'h0000_0600, 32'h4);
    runCycles(10, 1'b1, 1'b1);

    $display("[TB] PC wrap at top of address space");
    lat = 1;
    redirect(32'hFFFF_FFF0, 32'h0000_0008);
    runCycles(6, 1'b1, 1'b1);

    $display("[TB] reset with one fetch outstanding");
    runCycles(6, 1'b0, 1'b1);
    lat = 2;
    runCycles(1, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    runCycles(8, 1'b1, 1'b1);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      logic [31:0] off;
      if (i % 50 == 0) lat = 1 + int'($urandom % 3);
      off = ($urandom % 2 == 0) ? $urandom : 32'($urandom_range(0, 64));
      applyStimulus(1'b0, ($urandom % 4) != 0, ($urandom % 4) != 0,
                    ($urandom % 20) == 0, $urandom, off);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
